// File: rtl/pipe_segment_elastic.sv
// pipe_segment_elastic: elastic 2-entry pipeline segment register; optional stall/bubble counters under PIPE_SEG_STATS_EN
module pipe_segment_elastic #(
    parameter int CTRL_W = 2,
    parameter int DATA_W = 68
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy
`ifdef PIPE_SEG_STATS_EN
    ,
    output logic [15:0]       stall_cnt,
    output logic [15:0]       bubble_cnt
`endif
);
    typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_t;
    state_t state_q, state_d;
    logic [CTRL_W-1:0] main_ctrl, skid_ctrl;
    logic [DATA_W-1:0] main_data, skid_data;
    logic in_fire, out_fire, ld_main_in, ld_main_skid, ld_skid;
    assign in_ready  = state_q != FULL;
    assign out_valid = state_q != EMPTY;
    assign out_ctrl  = out_valid ? main_ctrl : '0;
    assign out_data  = main_data;
    assign occupancy = state_q;
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready;
    // next state and register load selects; flush forces a bubble and ignores both handshakes
    always_comb begin
        state_d      = state_q;
        ld_main_in   = 1'b0;
        ld_main_skid = 1'b0;
        ld_skid      = 1'b0;
        if (flush) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: begin
                    state_d    = in_fire ? ONE : EMPTY;
                    ld_main_in = in_fire;
                end
                ONE: begin
                    state_d    = (in_fire && !out_fire) ? FULL : (out_fire && !in_fire) ? EMPTY : ONE;
                    ld_main_in = in_fire & out_fire;
                    ld_skid    = in_fire & ~out_fire;
                end
                FULL: begin
                    state_d      = out_fire ? ONE : FULL;
                    ld_main_skid = out_fire;
                end
                default: state_d = EMPTY;
            endcase
        end
    end
    // state and storage update on the falling edge; data survives flush, ctrl does not
    always_ff @(negedge clk) begin
        if (rst) begin
            state_q   <= EMPTY;
            main_ctrl <= '0;
            skid_ctrl <= '0;
            main_data <= '0;
            skid_data <= '0;
        end else begin
            state_q <= state_d;
            if (flush) begin
                main_ctrl <= '0;
                skid_ctrl <= '0;
            end else begin
                if (ld_main_in) begin
                    main_ctrl <= in_ctrl;
                    main_data <= in_data;
                end else if (ld_main_skid) begin
                    main_ctrl <= skid_ctrl;
                    main_data <= skid_data;
                end
                if (ld_skid) begin
                    skid_ctrl <= in_ctrl;
                    skid_data <= in_data;
                end
            end
        end
    end
`ifdef PIPE_SEG_STATS_EN
    // saturating counters of stalled and empty cycles, cleared only by reset
    always_ff @(negedge clk) begin
        if (rst) begin
            stall_cnt  <= '0;
            bubble_cnt <= '0;
        end else begin
            if (out_valid && !out_ready && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
            if (!out_valid && bubble_cnt != 16'hFFFF) bubble_cnt <= bubble_cnt + 16'd1;
        end
    end
`endif
endmodule

// File: tb/tb_pipe_segment_elastic.sv
// tb_pipe_segment_elastic: scoreboard bench for pipe_segment_elastic against a FIFO-queue reference model
module tb_pipe_segment_elastic;
    logic clk = 1'b1;
    logic rst = 1'b1, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
    logic in_ready, out_valid;
    logic [1:0] in_ctrl = '0, out_ctrl, occupancy;
    logic [67:0] in_data = '0, out_data;
`ifdef PIPE_SEG_STATS_EN
    logic [15:0] stall_cnt, bubble_cnt;
`endif
    int checks = 0, failures = 0;
    logic [69:0] q[$];
    logic [69:0] last_head = '0;
    bit armed = 0;

    always #5 clk = ~clk;

    pipe_segment_elastic dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl), .out_data(out_data),
        .occupancy(occupancy)
`ifdef PIPE_SEG_STATS_EN
        , .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
`endif
    );

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // monitor: compares outputs with the model between falling edges, then advances the model
    always begin
        logic ofire, ifire;
        @(posedge clk);
        #1;
        if (armed) begin
            chk("occupancy", 128'(occupancy), 128'(q.size()));
            chk("in_ready", 128'(in_ready), 128'(q.size() < 2));
            chk("out_valid", 128'(out_valid), 128'(q.size() != 0));
            if (q.size() != 0) chk("head", 128'({out_ctrl, out_data}), 128'(q[0]));
            else begin
                chk("bubble_ctrl", 128'(out_ctrl), 128'(0));
                chk("bubble_data", 128'(out_data), 128'(last_head[67:0]));
            end
        end
        if (rst) begin
            q.delete();
            last_head = '0;
            armed = 1;
        end else if (armed) begin
            if (flush) q.delete();
            else begin
                ofire = (q.size() != 0) && out_ready;
                ifire = in_valid && (q.size() < 2);
                if (ofire) void'(q.pop_front());
                if (ifire) q.push_back({in_ctrl, in_data});
            end
            if (q.size() != 0) last_head = q[0];
        end
    end

    task automatic cyc(input logic v, input logic [1:0] c, input logic [67:0] d, input logic ordy,
                       input logic fl, input logic r);
        @(posedge clk);
        in_valid = v; in_ctrl = c; in_data = d; out_ready = ordy; flush = fl; rst = r;
    endtask

    task automatic send(input logic [1:0] c, input logic [67:0] d, input logic ordy);
        int n = 0;
        do begin
            cyc(1'b1, c, d, ordy, 1'b0, 1'b0);
            n++;
        end while (!in_ready && n < 50);
        if (!in_ready) begin
            checks++;
            failures++;
            $display("FAIL send_timeout: in_ready stayed %0b, required 1 within 50 cycles", in_ready);
        end
    endtask

    task automatic idle(input int n, input logic ordy);
        for (int i = 0; i < n; i++) cyc(1'b0, 2'b00, in_data, ordy, 1'b0, 1'b0);
    endtask

    initial begin
        logic [95:0] r;
        cyc(1'b0, 2'b00, '0, 1'b1, 1'b0, 1'b1);
        cyc(1'b0, 2'b00, '0, 1'b1, 1'b0, 1'b1);
        for (int i = 1; i <= 3; i++) send(2'b11, 68'(i), 1'b1);
        idle(2, 1'b1);
        send(2'b01, 68'hA, 1'b0);
        send(2'b10, 68'hB, 1'b0);
        idle(2, 1'b0);
        send(2'b11, 68'hC, 1'b1);
        idle(3, 1'b1);
        send(2'b01, 68'h11, 1'b0);
        send(2'b10, 68'h22, 1'b0);
        cyc(1'b1, 2'b11, 68'h33, 1'b1, 1'b1, 1'b0);
        idle(2, 1'b1);
        send(2'b01, 68'h44, 1'b0);
        send(2'b10, 68'h55, 1'b0);
        cyc(1'b1, 2'b11, 68'h66, 1'b1, 1'b1, 1'b1);
        idle(2, 1'b1);
        for (int i = 0; i < 2000; i++) begin
            r = {$urandom, $urandom, $urandom};
            cyc(1'($urandom_range(0, 1)), 2'($urandom), r[67:0], 1'($urandom_range(0, 2) != 0),
                1'($urandom_range(0, 99) < 3), 1'($urandom_range(0, 199) == 0));
        end
        idle(3, 1'b1);
`ifdef PIPE_SEG_STATS_EN
        cyc(1'b0, 2'b00, '0, 1'b1, 1'b0, 1'b1);
        cyc(1'b1, 2'b11, 68'h77, 1'b0, 1'b0, 1'b0);
        begin
            logic [15:0] s0, b0;
            idle(1, 1'b0);
            #1;
            s0 = stall_cnt;
            b0 = bubble_cnt;
            idle(4, 1'b0);
            idle(1, 1'b1);
            idle(3, 1'b1);
            idle(1, 1'b1);
            #1;
            chk("stall_cnt_delta", 128'(stall_cnt - s0), 128'(5));
            chk("bubble_cnt_delta", 128'(bubble_cnt - b0), 128'(3));
        end
        send(2'b11, 68'h88, 1'b0);
        idle(70000, 1'b0);
        #1;
        chk("stall_cnt_sat", 128'(stall_cnt), 128'(16'hFFFF));
`endif
        @(posedge clk);
        #2;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
